mseq_enc: RTL
=============

MSEQ_ENC -- requirements
Module: mseq_enc

Interface
REQ-001 SHALL have parameter TEMPLATE, default 31'b1100010110001011000101100010110, the 31-chip spreading sequence, transmitted TEMPLATE[30] first.
REQ-002 SHALL have parameter NBITS, default 8, the data bits per accepted word.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din  input  NBITS  data word to transmit.
REQ-006 SHALL have port din_valid  input  1  din holds a word to transmit.
REQ-007 SHALL have port din_ready  output  1  block accepts din on this edge.
REQ-008 SHALL have port signal  output  1  registered chip stream to the channel.
REQ-009 SHALL have port chip_idx  output  5  index of the TEMPLATE chip currently on signal, 30 down to 0.
REQ-010 SHALL have port sym_start  output  1  high while signal carries chip 30 of any symbol.
REQ-011 SHALL have port busy  output  1  high in PREAMBLE or DATA.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, PREAMBLE, DATA.
REQ-013 A transfer SHALL occur on an edge where din_valid and din_ready are both high; din is latched into a shift register on that edge.
REQ-014 din_ready SHALL be high in IDLE, and in DATA only during the final chip of the final bit (bit index 0, chip_idx 0); low otherwise.
REQ-015 IDLE: signal = 0, chip_idx = 0, sym_start = 0, busy = 0; a transfer moves to PREAMBLE.
REQ-016 PREAMBLE: one unmodulated TEMPLATE period (31 cycles); signal = TEMPLATE[chip_idx].
REQ-017 DATA: NBITS symbols of 31 chips each, latched word MSB first; signal = TEMPLATE[chip_idx] when the current bit is 1, and ~TEMPLATE[chip_idx] when it is 0.
REQ-018 Latency: signal SHALL carry chip 30 of the preamble in the cycle immediately after the transfer edge.
REQ-019 chip_idx SHALL decrement by 1 per cycle and wrap from 0 to 30 at each symbol boundary.
REQ-020 PREAMBLE -> DATA SHALL occur after preamble chip 0; DATA bit index SHALL advance after each chip 0.
REQ-021 At end of the last data chip, with a transfer: SHALL go directly to DATA with the new word, chip 30, no preamble (back-to-back).
REQ-022 At end of the last data chip, without a transfer: SHALL go to IDLE and drive signal to 0 on the next cycle.
REQ-023 din_valid while busy and din_ready low SHALL be ignored; the held din SHALL NOT be sampled.
REQ-024 A single isolated word SHALL occupy exactly 31 + 31*NBITS cycles of busy (279 for NBITS = 8).
REQ-025 din changes after a transfer SHALL NOT affect the word in flight.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, signal 0, chip_idx 0, sym_start 0, busy 0, din_ready 0, and clear the shift register and bit index.
REQ-027 din_ready SHALL return high on the first edge after rst_n deasserts.
REQ-028 Reset mid-PREAMBLE or mid-DATA SHALL abort the word; no residual chips SHALL follow.

Verification
REQ-029 Scenario: din = 8'hFF, one transfer -> 31 preamble chips, then TEMPLATE repeated 8 times; busy high exactly 279 cycles, then signal 0.
REQ-030 Scenario: din = 8'h00 -> preamble equals TEMPLATE; each of the 8 symbols equals ~TEMPLATE (first data chip 0, chips 30..27 = 0,0,1,1).
REQ-031 Scenario: din = 8'hA5 -> symbol polarity sequence T, ~T, T, ~T, ~T, T, ~T, T; sym_start pulses 9 times, 31 cycles apart.
REQ-032 Scenario: din_valid held high with words 8'h5A then 8'hC3 -> second word accepted on the last chip of the first; its bit 7 (1, TEMPLATE) starts the next cycle with no preamble; total busy 31 + 496 = 527 cycles.
REQ-033 Scenario: rst_n pulsed low at DATA bit 3, chip 12 -> signal 0 and busy 0 immediately; a new 8'hFF word then transmits normally, starting with the preamble.
REQ-034 Scenario: din_valid pulsed during PREAMBLE with din_ready low -> word not captured, and output identical to the first word only.

Source files
------------

// File: rtl/mseq_enc.sv
// mseq_enc: direct-sequence spreading encoder.
// Each accepted data word is sent as one unmodulated template period
// (the preamble) followed by NBITS symbols, MSB first. A symbol is the
// 31-chip template for a 1 bit and its complement for a 0 bit. A new word
// offered during the final chip of the final bit follows back-to-back
// without a preamble.
module mseq_enc #(
  parameter logic [30:0] TEMPLATE = 31'b1100010110001011000101100010110,
  parameter int          NBITS    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             signal,
  output logic [4:0]       chip_idx,
  output logic             sym_start,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  localparam int              BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(NBITS - 1);
  localparam logic [4:0]      CHIP_TOP = 5'd30;

  state_t             state_q, state_d;
  logic [4:0]         chip_q, chip_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NBITS-1:0]   sreg_q, sreg_d;
  logic               signal_q, signal_d;
  logic               sym_start_q, sym_start_d;
  // Holds din_ready low until the first edge after reset release.
  logic               rdy_en_q;
  logic               last_chip;
  logic               xfer;

  // Chip value for a given state/chip/data bit; the preamble is the plain template.
  function automatic logic chip_value(input state_t st, input logic [4:0] idx,
                                      input logic dbit);
    logic t;
    t = TEMPLATE[idx];
    case (st)
      PREAMBLE: chip_value = t;
      DATA:     chip_value = dbit ? t : ~t;
      default:  chip_value = 1'b0;
    endcase
  endfunction

  assign last_chip = (state_q == DATA) && (bit_q == '0) && (chip_q == 5'd0);
  assign din_ready = rdy_en_q && ((state_q == IDLE) || last_chip);
  assign xfer      = din_valid && din_ready;

  assign signal    = signal_q;
  assign chip_idx  = chip_q;
  assign sym_start = sym_start_q;
  assign busy      = (state_q != IDLE);

  // Next-state, chip/bit counters, word shift register and next output chip.
  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = PREAMBLE;
          chip_d  = CHIP_TOP;
          bit_d   = LAST_BIT;
          sreg_d  = din;
        end
      end
      PREAMBLE: begin
        if (chip_q == 5'd0) begin
          state_d = DATA;
          chip_d  = CHIP_TOP;
        end else begin
          chip_d = chip_q - 5'd1;
        end
      end
      DATA: begin
        if (chip_q != 5'd0) begin
          chip_d = chip_q - 5'd1;
        end else if (bit_q != '0) begin
          chip_d = CHIP_TOP;
          bit_d  = bit_q - BW'(1);
          sreg_d = sreg_q << 1;
        end else if (xfer) begin
          // Back-to-back word: straight into data, no preamble.
          chip_d = CHIP_TOP;
          bit_d  = LAST_BIT;
          sreg_d = din;
        end else begin
          state_d = IDLE;
          chip_d  = 5'd0;
          bit_d   = '0;
          sreg_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        chip_d  = 5'd0;
        bit_d   = '0;
        sreg_d  = '0;
      end
    endcase
    signal_d    = chip_value(state_d, chip_d, sreg_d[NBITS-1]);
    sym_start_d = (state_d != IDLE) && (chip_d == CHIP_TOP);
  end

  // All state and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chip_q      <= 5'd0;
      bit_q       <= '0;
      sreg_q      <= '0;
      signal_q    <= 1'b0;
      sym_start_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_q      <= chip_d;
      bit_q       <= bit_d;
      sreg_q      <= sreg_d;
      signal_q    <= signal_d;
      sym_start_q <= sym_start_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule
